// File: rtl/difficulty_controller_if.sv
// Board-side signal bundle for the difficulty controller: raw buttons and
// game state in, selected difficulty, start request and display state out.
interface difficulty_controller_if;
    logic        BTNL;
    logic        BTNC;
    logic        BTNR;
    logic        BTNU;
    logic [31:0] game_state;
    logic [31:0] difficulty;
    logic        start_pulse;
    logic [1:0]  ctrl_state;
    logic [2:0]  sel_led;

    // Strobe semantics: start_pulse is a single-cycle request with no ready;
    // the processor must sample it on the cycle it is high.
    modport master (
        output BTNL, BTNC, BTNR, BTNU, game_state,
        input  difficulty, start_pulse, ctrl_state, sel_led
    );

    modport slave (
        input  BTNL, BTNC, BTNR, BTNU, game_state,
        output difficulty, start_pulse, ctrl_state, sel_led
    );
endinterface

// File: rtl/difficulty_controller.sv
// Debounced four-button difficulty menu with a round-start handshake to the
// processor and a watchdog that re-arms if the round never begins.
module difficulty_controller #(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] GS_PLAYING      = 32'd1,
    parameter logic [31:0] GS_OVER         = 32'd2
) (
    input  logic                    clock,
    input  logic                    anti_reset,
    difficulty_controller_if.slave  bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2,
        OVER    = 2'd3
    } state_t;

    // Button index order: 0=L, 1=C, 2=R, 3=U.
    logic [3:0]    btn_raw;
    logic [3:0]    s1_q, s2_q, stable_q, prev_q;
    logic [CW-1:0] cnt_q [4];
    logic [3:0]    ev;

    assign btn_raw = {bus.BTNU, bus.BTNR, bus.BTNC, bus.BTNL};
    assign ev      = stable_q & ~prev_q;

    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            s1_q   <= btn_raw;
            s2_q   <= s1_q;
            prev_q <= stable_q;
            for (int i = 0; i < 4; i++) begin
                if (s2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_q[i] <= s2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_t      state_q, state_d;
    logic [1:0]  diff_q, diff_d;
    logic        start_q, start_d;
    logic [15:0] timer_q, timer_d;
    logic        seen_q, seen_d;
    logic        sel_any;
    logic [1:0]  sel_val;

    assign sel_any = |ev[2:0];
    assign sel_val = ev[0] ? 2'd1 : (ev[1] ? 2'd2 : 2'd3);

    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            state_q <= MENU;
            diff_q  <= 2'd1;
            start_q <= 1'b0;
            timer_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            start_q <= start_d;
            timer_q <= timer_d;
            seen_q  <= seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        start_d = 1'b0;
        timer_d = timer_q;
        seen_d  = seen_q;
        case (state_q)
            MENU: begin
                if (sel_any) begin
                    diff_d  = sel_val;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // A selection in the same cycle as confirm wins; no start.
                if (sel_any) begin
                    diff_d = sel_val;
                end else if (ev[3]) begin
                    start_d = 1'b1;
                    state_d = RUNNING;
                    timer_d = '0;
                    seen_d  = 1'b0;
                end
            end
            RUNNING: begin
                timer_d = timer_q + 16'd1;
                if (bus.game_state == GS_PLAYING) seen_d = 1'b1;
                if (bus.game_state == GS_OVER) begin
                    state_d = OVER;
                end else if (!seen_q && bus.game_state != GS_PLAYING &&
                             timer_q == 16'hFFFF) begin
                    state_d = ARMED;
                end
            end
            OVER: begin
                if (ev[3]) state_d = MENU;
            end
            default: state_d = MENU;
        endcase
    end

    assign bus.difficulty  = {30'd0, diff_q};
    assign bus.start_pulse = start_q;
    assign bus.ctrl_state  = state_q;
    assign bus.sel_led     = {diff_q == 2'd3, diff_q == 2'd2, diff_q == 2'd1};
endmodule

// File: tb/tb_difficulty_controller.sv
// Directed bench for difficulty_controller with a short debounce window.
module tb_difficulty_controller;
    localparam int N = 4;

    logic clock;
    logic anti_reset;
    int   total;
    int   bad;
    int   start_count;
    int   start_double;
    logic start_prev;

    difficulty_controller_if dc_if ();

    difficulty_controller #(
        .DEBOUNCE_CYCLES(N),
        .GS_PLAYING(32'd1),
        .GS_OVER(32'd2)
    ) dut (
        .clock(clock),
        .anti_reset(anti_reset),
        .bus(dc_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_btns(input logic [3:0] m);
        dc_if.BTNL = m[0];
        dc_if.BTNC = m[1];
        dc_if.BTNR = m[2];
        dc_if.BTNU = m[3];
    endtask

    always @(negedge clock) begin
        if (dc_if.start_pulse === 1'b1) begin
            start_count++;
            if (start_prev === 1'b1) start_double++;
        end
        start_prev = dc_if.start_pulse;
    end

    initial begin
        total = 0; bad = 0; start_count = 0; start_double = 0; start_prev = 1'b0;
        set_btns(4'b0000);
        dc_if.game_state = 32'd0;
        anti_reset = 1'b0;
        tick(3);
        chk("rst_diff", dc_if.difficulty, 32'd1);
        chk("rst_start", {31'd0, dc_if.start_pulse}, 32'd0);
        chk("rst_state", {30'd0, dc_if.ctrl_state}, 32'd0);
        chk("rst_led", {29'd0, dc_if.sel_led}, 32'd1);
        anti_reset = 1'b1;
        tick(2);

        // BTNC held 10 cycles: selection lands on edge N+3
        set_btns(4'b0010);
        tick(N + 2);
        chk("c_early_state", {30'd0, dc_if.ctrl_state}, 32'd0);
        tick(1);
        chk("c_state", {30'd0, dc_if.ctrl_state}, 32'd1);
        chk("c_diff", dc_if.difficulty, 32'd2);
        chk("c_led", {29'd0, dc_if.sel_led}, 32'd2);
        tick(3);
        set_btns(4'b0000);
        tick(8);
        chk("c_hold_state", {30'd0, dc_if.ctrl_state}, 32'd1);

        // 3-cycle glitch on BTNR is filtered
        set_btns(4'b0100);
        tick(3);
        set_btns(4'b0000);
        tick(10);
        chk("glitch_diff", dc_if.difficulty, 32'd2);
        chk("glitch_state", {30'd0, dc_if.ctrl_state}, 32'd1);

        // Confirm: one start pulse, RUNNING
        set_btns(4'b1000);
        tick(N + 3);
        chk("u_start", {31'd0, dc_if.start_pulse}, 32'd1);
        chk("u_state", {30'd0, dc_if.ctrl_state}, 32'd2);
        tick(1);
        chk("u_start_end", {31'd0, dc_if.start_pulse}, 32'd0);
        dc_if.game_state = 32'd1;
        set_btns(4'b0000);
        tick(8);
        set_btns(4'b0001);
        tick(N + 3);
        set_btns(4'b0000);
        tick(8);
        chk("run_frozen_diff", dc_if.difficulty, 32'd2);
        chk("run_state", {30'd0, dc_if.ctrl_state}, 32'd2);

        // Game over, then acknowledge back to MENU
        dc_if.game_state = 32'd2;
        tick(1);
        chk("over_state", {30'd0, dc_if.ctrl_state}, 32'd3);
        dc_if.game_state = 32'd0;
        set_btns(4'b1000);
        tick(N + 3);
        chk("ack_state", {30'd0, dc_if.ctrl_state}, 32'd0);
        chk("ack_diff", dc_if.difficulty, 32'd2);
        set_btns(4'b0000);
        tick(8);

        // L+R together in MENU -> L wins
        set_btns(4'b0101);
        tick(N + 3);
        chk("lr_diff", dc_if.difficulty, 32'd1);
        chk("lr_state", {30'd0, dc_if.ctrl_state}, 32'd1);
        set_btns(4'b0000);
        tick(8);

        // U+R together in ARMED -> selection only
        set_btns(4'b1100);
        tick(N + 3);
        chk("ur_diff", dc_if.difficulty, 32'd3);
        chk("ur_led", {29'd0, dc_if.sel_led}, 32'd4);
        chk("ur_start", {31'd0, dc_if.start_pulse}, 32'd0);
        tick(1);
        chk("ur_state", {30'd0, dc_if.ctrl_state}, 32'd1);
        set_btns(4'b0000);
        tick(8);

        // Start never acknowledged: re-arm after 65536 cycles
        set_btns(4'b1000);
        tick(N + 3);
        chk("wd_enter", {30'd0, dc_if.ctrl_state}, 32'd2);
        set_btns(4'b0000);
        tick(65535);
        chk("wd_before", {30'd0, dc_if.ctrl_state}, 32'd2);
        tick(1);
        chk("wd_after", {30'd0, dc_if.ctrl_state}, 32'd1);
        tick(4);

        // Reset mid-round acts immediately
        set_btns(4'b1000);
        tick(N + 3);
        chk("r2_enter", {30'd0, dc_if.ctrl_state}, 32'd2);
        set_btns(4'b0000);
        tick(6);
        #2;
        anti_reset = 1'b0;
        #1;
        chk("async_state", {30'd0, dc_if.ctrl_state}, 32'd0);
        chk("async_diff", dc_if.difficulty, 32'd1);
        chk("async_led", {29'd0, dc_if.sel_led}, 32'd1);
        chk("async_start", {31'd0, dc_if.start_pulse}, 32'd0);

        // BTNR held through reset release -> one event N+3 after release
        tick(1);
        set_btns(4'b0100);
        tick(10);
        chk("inrst_state", {30'd0, dc_if.ctrl_state}, 32'd0);
        anti_reset = 1'b1;
        tick(N + 2);
        chk("held_early", {30'd0, dc_if.ctrl_state}, 32'd0);
        tick(1);
        chk("held_state", {30'd0, dc_if.ctrl_state}, 32'd1);
        chk("held_diff", dc_if.difficulty, 32'd3);
        set_btns(4'b0000);
        tick(8);

        // C+R together -> C wins
        set_btns(4'b0110);
        tick(N + 3);
        chk("cr_diff", dc_if.difficulty, 32'd2);
        set_btns(4'b0000);
        tick(8);

        chk("start_total", start_count, 32'd3);
        chk("start_double", start_double, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
